uart_rx: RTL and testbench

//   8N1 asynchronous serial receiver. Deserialises the host UART line into bytes.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   // Width of a down-counter that must hold CLKS_PER_BAUD-1.
   function automatic int unsigned baud_cnt_w(input int unsigned clks_per_baud);
      int unsigned w;
      w = (clks_per_baud <= 2) ? 32'd1 : 32'($clog2(clks_per_baud));
      return w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = i_d;
      sync_d = meta_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte strobe, one-shot framing error.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BAUD = 434
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_stb,
   output logic       o_frame_err
);

   localparam int unsigned CNT_W = baud_cnt_w(CLKS_PER_BAUD);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BAUD - 1);
   localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLKS_PER_BAUD / 2 - 1);

   logic           rxs;
   logic           sample;

   uart_rx_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]     bitn_q, bitn_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     data_q, data_d;
   logic           stb_q, stb_d;
   logic           ferr_q, ferr_d;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rxs)
   );

   assign sample = (cnt_q == '0);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bitn_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         stb_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bitn_q  <= bitn_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         stb_q   <= stb_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bitn_d  = bitn_q;
      shift_d = shift_q;
      data_d  = data_q;
      stb_d   = 1'b0;
      ferr_d  = 1'b0;

      // Bit timer runs whenever a frame is in progress; zero marks the sample point.
      if (state_q != IDLE) begin
         cnt_d = sample ? CNT_RELOAD : cnt_q - CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d = START;
               cnt_d   = CNT_HALF;
            end
         end
         START: begin
            if (sample) begin
               if (rxs) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bitn_d  = 3'd0;
               end
            end
         end
         DATA: begin
            if (sample) begin
               shift_d = {rxs, shift_q[7:1]};
               if (bitn_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bitn_d = bitn_q + 3'd1;
               end
            end
         end
         STOP: begin
            // Leave at mid-stop so an immediately following start bit is caught.
            if (sample) begin
               if (rxs) begin
                  data_d  = shift_q;
                  stb_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            if (rxs) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_data      = data_q;
   assign o_stb       = stb_q;
   assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: bit-banged stimulus, expectations queued, monitor checks strobes.
module tb_uart_rx;
   import uart_pkg::*;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      longint     cyc;     // -1: timing not checked
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx16 = 1'b1;
   logic       rx434 = 1'b1;
   logic [7:0] data16, data434;
   logic       stb16, stb434;
   logic       ferr16, ferr434;

   exp_t   q16[$];
   exp_t   q434[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.CLKS_PER_BAUD(16)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_rx        (rx16),
      .o_data      (data16),
      .o_stb       (stb16),
      .o_frame_err (ferr16)
   );

   uart_rx #(.CLKS_PER_BAUD(434)) dut_slow (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_rx        (rx434),
      .o_data      (data434),
      .o_stb       (stb434),
      .o_frame_err (ferr434)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance n clock edges, leaving the stimulus point 1 time unit after the last edge.
   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx434 = v;
      else     rx16  = v;
   endtask

   // kind: 0 = no response, 1 = byte strobe, 2 = framing error
   task automatic send(input bit sel, input logic [7:0] b, input int bc, input logic stop_v,
                       input int kind, input logic [7:0] exp_data);
      exp_t e;
      set_rx(sel, 1'b0);
      if (kind != 0) begin
         e.is_err = (kind == 2);
         e.data   = exp_data;
         e.cyc    = sel ? -1 : cyc + 155;  // 2 sync + 1 detect + 8 + 144
         if (sel) q434.push_back(e);
         else     q16.push_back(e);
      end
      hold(bc);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, b[i]);
         hold(bc);
      end
      set_rx(sel, stop_v);
      hold(bc);
   endtask

   task automatic mon(input bit sel, input logic stb, input logic ferr, input logic [7:0] d);
      exp_t e;
      string tag;
      tag = sel ? "434" : "16";
      if (stb || ferr) begin
         chk({"strobe_exclusive_", tag}, 64'(stb & ferr), 64'd0);
         if ((sel ? q434.size() : q16.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event_%s: stb=%0b ferr=%0b data=%0h required none (cycle %0d)",
                     tag, stb, ferr, d, cyc);
         end else begin
            e = sel ? q434.pop_front() : q16.pop_front();
            chk({"event_kind_", tag}, 64'(ferr), 64'(e.is_err));
            chk({"data_", tag}, 64'(d), 64'(e.data));
            if (e.cyc >= 0) chk({"latency_", tag}, 64'(cyc), 64'(e.cyc));
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(1'b0, stb16, ferr16, data16);
         mon(1'b1, stb434, ferr434, data434);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      hold(3);
      chk("reset_data", 64'(data16), 64'h00);
      chk("reset_stb", 64'(stb16), 64'd0);
      chk("reset_ferr", 64'(ferr16), 64'd0);
      chk("reset_state", 64'(dut.state_q), 64'(IDLE));
      rst = 1'b0;
      hold(10);

      // Single good frame with latency check
      send(1'b0, 8'h3A, 16, 1'b1, 1, 8'h3A);
      hold(20);

      // Short glitch is a false start
      rx16 = 1'b0;
      hold(5);
      rx16 = 1'b1;
      hold(30);
      chk("glitch_idle", 64'(dut.state_q), 64'(IDLE));
      send(1'b0, 8'h41, 16, 1'b1, 1, 8'h41);
      hold(20);

      // Bad stop bit followed by a long low line: one framing error, data unchanged
      send(1'b0, 8'h55, 16, 1'b0, 2, 8'h41);
      hold(40);
      rx16 = 1'b1;
      hold(20);
      chk("break_idle", 64'(dut.state_q), 64'(IDLE));
      chk("break_data_kept", 64'(data16), 64'h41);
      send(1'b0, 8'h30, 16, 1'b1, 1, 8'h30);
      hold(20);

      // Back-to-back frames, no idle gap
      send(1'b0, 8'h30, 16, 1'b1, 1, 8'h30);
      send(1'b0, 8'h31, 16, 1'b1, 1, 8'h31);
      send(1'b0, 8'h46, 16, 1'b1, 1, 8'h46);
      hold(20);

      // Reset in the middle of bit 4 of 0xFF
      rx16 = 1'b0;
      hold(16);
      rx16 = 1'b1;
      hold(16 * 4 + 8);
      rst = 1'b1;
      hold(1);
      rst = 1'b0;
      chk("midreset_data", 64'(data16), 64'h00);
      chk("midreset_stb", 64'(stb16), 64'd0);
      chk("midreset_ferr", 64'(ferr16), 64'd0);
      chk("midreset_state", 64'(dut.state_q), 64'(IDLE));
      hold(8 + 16 * 4 + 10);
      send(1'b0, 8'hA5, 16, 1'b1, 1, 8'hA5);
      hold(20);

      // Baud mismatch at 434 clocks per bit: 3% fast, then 3% slow
      send(1'b1, 8'h00, 421, 1'b1, 1, 8'h00);
      hold(100);
      send(1'b1, 8'hFF, 421, 1'b1, 1, 8'hFF);
      hold(100);
      send(1'b1, 8'h00, 447, 1'b1, 1, 8'h00);
      hold(100);
      send(1'b1, 8'hFF, 447, 1'b1, 1, 8'hFF);
      hold(600);

      chk("pending_16", 64'(q16.size()), 64'd0);
      chk("pending_434", 64'(q434.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
